// File: rtl/pack_pkg.sv
// Shared constants and queue entry type for the 2-bit to 8-bit packer.
// With PACK2_TO_8_PARITY_EN defined each entry also carries a parity bit.
package pack_pkg;

    localparam int SYM_W  = 2;
    localparam int SYMS   = 4;
    localparam int WORD_W = SYM_W * SYMS;
    localparam int QDEPTH = 2;

    typedef struct packed {
        logic [WORD_W-1:0] word;
`ifdef PACK2_TO_8_PARITY_EN
        logic              par;
`endif
    } q_entry_t;

endpackage

// File: rtl/pack_fifo2.sv
// Two-entry FIFO holding completed words for the byte-wide consumer.
// Ports: clk, reset_L, push, pop, din, head, count (0..2), full.
module pack_fifo2 (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                push,
    input  logic                pop,
    input  pack_pkg::q_entry_t  din,
    output pack_pkg::q_entry_t  head,
    output logic [1:0]          count,
    output logic                full
);
    import pack_pkg::*;

    q_entry_t   slot0;
    q_entry_t   slot1;
    logic       pop_ok;
    logic       push_ok;
    logic [1:0] wr_idx;

    assign full    = (count == 2'd2);
    assign pop_ok  = pop & (count != 2'd0);
    // A push into a full queue is only taken when a pop frees a slot.
    assign push_ok = push & (~full | pop_ok);
    assign wr_idx  = count - {1'b0, pop_ok};
    assign head    = slot0;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            // Popping the only entry leaves slot0 untouched, so the
            // head keeps showing the last popped word.
            if (pop_ok && count == 2'd2)
                slot0 <= slot1;
            if (push_ok) begin
                if (wr_idx == 2'd0)
                    slot0 <= din;
                else
                    slot1 <= din;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/pack2_to_8.sv
// Packs four 2-bit symbols LSB-first into bytes queued in a 2-entry FIFO.
// Ports: clk, reset_L, valid_in, data_in, ready_in, data_out, valid_out,
// overflow (sticky drop flag); parity_out only with PACK2_TO_8_PARITY_EN.
module pack2_to_8 #(
    parameter int SYM_W = 2,
    parameter int SYMS  = 4
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               valid_in,
    input  logic [SYM_W-1:0]   data_in,
    input  logic               ready_in,
    output logic [SYM_W*SYMS-1:0] data_out,
    output logic               valid_out,
    output logic               overflow
`ifdef PACK2_TO_8_PARITY_EN
   ,output logic               parity_out
`endif
);
    import pack_pkg::*;

    localparam int CW = $clog2(SYMS);
    localparam int PW = SYM_W * (SYMS - 1);

    logic [CW-1:0] cnt;
    logic [PW-1:0] partial;
    logic          last;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic [1:0]    occ;
    q_entry_t      entry;
    q_entry_t      head;

    assign last = (cnt == CW'(SYMS - 1));
    assign push = valid_in & last;
    assign pop  = valid_out & ready_in;
    // The mux stage cannot stall, so a word with nowhere to go is lost.
    assign drop = push & full & ~pop;

    always_comb begin
        entry      = '0;
        entry.word = {data_in, partial};
`ifdef PACK2_TO_8_PARITY_EN
        entry.par  = ^{data_in, partial};
`endif
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt      <= '0;
            partial  <= '0;
            overflow <= 1'b0;
        end else begin
            if (valid_in) begin
                if (last) begin
                    cnt     <= '0;
                    partial <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    partial[cnt*SYM_W +: SYM_W] <= data_in;
                end
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

    pack_fifo2 u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (push & ~drop),
        .pop     (pop),
        .din     (entry),
        .head    (head),
        .count   (occ),
        .full    (full)
    );

    assign valid_out  = (occ != 2'd0);
    assign data_out   = head.word;
`ifdef PACK2_TO_8_PARITY_EN
    assign parity_out = head.par;
`endif

endmodule

// File: doc/pack2_to_8.md
# pack2_to_8

- Serial-to-parallel packer that sits directly downstream of the registered 2-bit 2:1 multiplexer stage.
- Collects four consecutive valid 2-bit symbols into one 8-bit word.
- Completed words are held in a 2-entry output queue under a valid/ready handshake toward the byte-wide consumer.
- The mux stage cannot be stalled, so the packer never back-pressures upstream. Loss is reported through a sticky overflow flag.

## Interface

Parameters:
- SYM_W, default 2: symbol width; must match the mux data width.
- SYMS, default 4: symbols per word. WORD_W = SYM_W*SYMS = 8.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_L, input, 1: reset, asynchronous and active-low; clears all state immediately.
- valid_in, input, 1: data_in carries a symbol this cycle.
- data_in, input, SYM_W: symbol from the mux stage.
- ready_in, input, 1: downstream consumer accepts data_out this cycle.
- data_out, output, WORD_W: head word of the output queue.
- valid_out, output, 1: queue is non-empty.
- overflow, output, 1: sticky flag; set when a completed word was dropped.
- parity_out, output, 1: present only with PACK2_TO_8_PARITY_EN.

## Operation

- Symbol counter (2-bit, 0..3) and 3-symbol partial register.
- Every cycle with valid_in=1 consumes one symbol. No cycle drops a symbol except as described under overflow.
- Packing is LSB-first: symbol k lands in data_out[2k+1:2k].
- When count=3 and valid_in=1, the word {data_in, partial} is complete:
  - The word is pushed to the queue.
  - The counter wraps to 0.
  - The partial register is cleared to 0.
- Output queue: 2-entry FIFO with occupancy 0..2.
  - Pop occurs when valid_out=1 and ready_in=1.
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged.
- Overflow: push while occupancy=2 with no pop that cycle.
  - The new word is discarded and the queue is unchanged.
  - The counter still wraps to 0.
  - overflow goes to 1 and stays 1 until reset.
- Pop from an empty queue is impossible because valid_out=0. ready_in is ignored while empty.
- data_out while the queue is empty holds the last popped value, or 0 after reset. The value is don't-care for checking.

## Timing

- Reset values: valid_out=0, data_out=8'h00, overflow=0, parity_out=0, counter=0, occupancy=0. Any partial word is lost.
- Reset asserted mid-word or with the queue full clears everything asynchronously. The first valid_in after deassertion is symbol 0 of a new word.
- Latency:
  - The 4th symbol is sampled at edge N.
  - valid_out=1 and data_out=word are visible after edge N.
  - The word can be popped at edge N+1 at the earliest.
- Throughput: sustained 1 word per 4 valid cycles. With ready_in held at 1, the queue never exceeds 1 entry.
- valid_in=0 cycles are gaps: the counter and partial register hold.
- data_out and valid_out are stable while valid_out=1 and ready_in=0.

## Configuration

- PACK2_TO_8_PARITY_EN defined:
  - Each queue entry stores one extra bit, the XOR of its 8 data bits, computed at push.
  - parity_out presents the head entry's bit, aligned with data_out.
- Macro undefined: the parity_out port, the extra storage and the parity logic are absent. All other behaviour is identical.

## Structure

- Package pack_pkg holds:
  - Constants SYM_W=2, SYMS=4, WORD_W=8, QDEPTH=2.
  - Typedef of the queue entry: word, plus the parity bit when enabled.
- Sub-module pack_fifo2 implements the 2-entry FIFO: push, pop, head, occupancy and full.
- The top level contains the counter, the partial register, push/overflow logic and the parity compute.

## Test plan

- Reset, then symbols 01,10,11,00 on consecutive cycles with ready_in=1:
  - data_out=8'h39 with valid_out=1 for exactly one cycle, one cycle after the 4th symbol.
  - parity_out=0 when enabled.
- Same symbols with valid_in=0 gaps between them: the identical word 8'h39 is produced. Gaps do not advance the counter.
- ready_in=0 and 12 symbols forming words 8'h39, 8'hFF, 8'h00:
  - First two words are queued.
  - Third is dropped and overflow=1.
  - Raising ready_in pops 8'h39 then 8'hFF, and overflow stays 1.
- Queue holds 2 entries and the 4th symbol arrives in the same cycle as a pop (ready_in=1): no overflow, and occupancy stays 2.
- reset_L pulsed low after 2 symbols and with 1 queued word:
  - valid_out=0 immediately.
  - Next 4 symbols 11,11,11,11 yield 8'hFF.
  - parity_out=0 with parity enabled.
- Continuous valid_in for 64 cycles with random ready_in: a scoreboard matches every word LSB-first and counts drops equal to overflow events.
